program_loader: RTL and testbench

//  Byte-stream boot loader: the write side of the instruction memory that the pipelined core fetches from.

---
 rtl/program_loader_if.sv | 29 ++
 rtl/program_loader.sv | 167 ++++++++++++++++
 tb/tb_program_loader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write signals of the boot loader.
// slave  : loader side (consumes bytes, drives the memory write port)
// master : host/bench side (offers bytes, observes the memory write port)
interface program_loader_if;
    logic [7:0]  Byte_i;
    logic        Byte_Valid_i;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Data_o;

    modport slave (
        input  Byte_i,
        input  Byte_Valid_i,
        output Byte_Ready_o,
        output Mem_Write_o,
        output Mem_Address_o,
        output Mem_Data_o
    );

    modport master (
        output Byte_i,
        output Byte_Valid_i,
        input  Byte_Ready_o,
        input  Mem_Write_o,
        input  Mem_Address_o,
        input  Mem_Data_o
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: assembles a length-prefixed little-endian byte stream into
// 32-bit words, writes them to program memory and releases the core's
// active-low reset once the image is complete.
// Optional feature macro: PROGRAM_LOADER_CHECKSUM_EN (trailing XOR byte).
//
// state  | meaning
// -------+-----------------------------------------------------------
// HDR_LO | waiting for count[7:0]
// HDR_HI | waiting for count[15:8]; decides ERROR / CHECK / DATA
// DATA   | collecting the 4 bytes of the current word, LSB first
// WRITE  | one-cycle memory write strobe for the assembled word
// CHECK  | end of image (waits for the checksum byte when enabled)
// DONE   | image loaded, core released
// ERROR  | length overflow or checksum mismatch, core held in reset
module program_loader #(
    parameter int          MEMORY_DEPTH = 64,
    parameter logic [31:0] BASE_ADDR    = 32'h0040_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    Start_i,
    program_loader_if.slave         bus,
    output logic                    Core_Reset_o,
    output logic                    Done_o,
    output logic                    Error_o
);

    typedef enum logic [2:0] {
        HDR_LO,
        HDR_HI,
        DATA,
        WRITE,
        CHECK,
        DONE,
        ERROR
    } state_t;

    localparam logic [16:0] DEPTH_LIMIT = 17'(MEMORY_DEPTH);

    state_t      state_q;
    state_t      state_d;
    logic [15:0] count_q;
    logic [15:0] word_index_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] data_q;
    logic [15:0] hdr_count;
    logic        accept;
    logic        last_word;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    assign accept    = bus.Byte_Valid_i & bus.Byte_Ready_o;
    assign hdr_count = {bus.Byte_i, count_q[7:0]};
    assign last_word = (({1'b0, word_index_q} + 17'd1) == {1'b0, count_q});

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= HDR_LO;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode
    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR_LO: begin
                if (accept) state_d = HDR_HI;
            end
            HDR_HI: begin
                if (accept) begin
                    if ({1'b0, hdr_count} > DEPTH_LIMIT) state_d = ERROR;
                    else if (hdr_count == 16'd0)         state_d = CHECK;
                    else                                 state_d = DATA;
                end
            end
            DATA: begin
                if (accept && byte_cnt_q == 2'd3) state_d = WRITE;
            end
            WRITE: begin
                state_d = last_word ? CHECK : DATA;
            end
            CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                if (accept) state_d = (bus.Byte_i == csum_q) ? DONE : ERROR;
`else
                state_d = DONE;
`endif
            end
            DONE, ERROR: begin
                if (Start_i) state_d = HDR_LO;
            end
            default: state_d = HDR_LO;
        endcase
    end

    // Handshake and status outputs, decoded from state only
    always_comb begin
        bus.Byte_Ready_o = 1'b0;
        bus.Mem_Write_o  = 1'b0;
        Core_Reset_o     = 1'b0;
        Done_o           = 1'b0;
        Error_o          = 1'b0;
        case (state_q)
            HDR_LO, HDR_HI, DATA: bus.Byte_Ready_o = 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            CHECK:                bus.Byte_Ready_o = 1'b1;
`endif
            WRITE:                bus.Mem_Write_o  = 1'b1;
            DONE: begin
                Core_Reset_o = 1'b1;
                Done_o       = 1'b1;
            end
            ERROR:                Error_o          = 1'b1;
            default: ;
        endcase
    end

    // Header latch, word assembly and word index; word_index never exceeds
    // MEMORY_DEPTH so the 32-bit address cannot wrap
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q      <= '0;
            word_index_q <= '0;
            byte_cnt_q   <= '0;
            data_q       <= '0;
        end else begin
            if (accept) begin
                case (state_q)
                    HDR_LO: count_q[7:0] <= bus.Byte_i;
                    HDR_HI: begin
                        count_q[15:8] <= bus.Byte_i;
                        word_index_q  <= '0;
                        byte_cnt_q    <= '0;
                    end
                    DATA: begin
                        data_q[{byte_cnt_q, 3'b000} +: 8] <= bus.Byte_i;
                        byte_cnt_q                         <= byte_cnt_q + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (state_q == WRITE) begin
                word_index_q <= word_index_q + 16'd1;
            end
        end
    end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    // Running XOR of data bytes; header bytes are excluded
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            csum_q <= '0;
        end else if (accept) begin
            if (state_q == HDR_HI)    csum_q <= '0;
            else if (state_q == DATA) csum_q <= csum_q ^ bus.Byte_i;
        end
    end
`endif

    assign bus.Mem_Address_o = BASE_ADDR + {14'd0, word_index_q, 2'b00};
    assign bus.Mem_Data_o    = data_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: the stimulus side pushes the expected
// memory writes derived from each image, a monitor pops and compares every
// write strobe it observes.
module tb_program_loader;

    localparam int          DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0040_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic reset;
    logic start;
    logic core_reset;
    logic done;
    logic error;

    program_loader_if bus();

    program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk          (clk),
        .reset        (reset),
        .Start_i      (start),
        .bus          (bus),
        .Core_Reset_o (core_reset),
        .Done_o       (done),
        .Error_o      (error)
    );

    int          n_cmp = 0;
    int          n_fail = 0;
    int          last_wait;
    wr_t         exp_q[$];
    logic [31:0] img_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write
    always @(negedge clk) begin
        if (reset && bus.Mem_Write_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", bus.Mem_Address_o, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", bus.Mem_Address_o, e.addr);
                check("write_data", bus.Mem_Data_o, e.data);
                check("ready_in_write", {31'd0, bus.Byte_Ready_o}, 32'd0);
            end
        end
    end

    // Offer one byte and hold it until accepted; mode 0 full valid,
    // 1 one idle cycle before each byte, 2 random idle cycles
    task automatic send_byte(input logic [7:0] b, input int mode);
        int idle;
        int budget;
        idle = (mode == 1) ? 1 : (mode == 2) ? int'($urandom_range(0, 2)) : 0;
        bus.Byte_Valid_i = 1'b0;
        repeat (idle) begin
            @(posedge clk);
            #1;
        end
        bus.Byte_i       = b;
        bus.Byte_Valid_i = 1'b1;
        budget           = 0;
        @(negedge clk);
        while (!bus.Byte_Ready_o && budget < 50) begin
            budget++;
            @(negedge clk);
        end
        if (!bus.Byte_Ready_o) begin
            check("byte_accept_timeout", 32'd0, 32'd1);
            bus.Byte_Valid_i = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        bus.Byte_Valid_i = 1'b0;
    endtask

    task automatic wait_outcome(input bit exp_done);
        int n;
        n = 0;
        while (!(done || error) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        last_wait = n;
        check("done_flag", {31'd0, done}, {31'd0, exp_done});
        check("error_flag", {31'd0, error}, {31'd0, !exp_done});
        check("core_reset", {31'd0, core_reset}, {31'd0, exp_done});
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("restart_done", {31'd0, done}, 32'd0);
        check("restart_error", {31'd0, error}, 32'd0);
        check("restart_core_reset", {31'd0, core_reset}, 32'd0);
        check("restart_ready", {31'd0, bus.Byte_Ready_o}, 32'd1);
    endtask

    // Reference model: an image of 'count' words is accepted when it fits in
    // memory (and its trailer equals the XOR of the data bytes); each word i
    // lands at BASE + 4*i regardless of the final verdict.
    task automatic run_image(input int count, input int mode, input bit corrupt);
        bit          ok;
        logic [7:0]  csum;
        logic [15:0] cnt16;
        logic [31:0] w;
        wr_t         e;
        cnt16 = 16'(count);
        ok    = (count <= DEPTH);
        csum  = 8'h00;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        if (corrupt) ok = 1'b0;
`endif
        if (count <= DEPTH) begin
            for (int i = 0; i < count; i++) begin
                e.addr = BASE + 32'(4 * i);
                e.data = img_q[i];
                exp_q.push_back(e);
            end
        end
        send_byte(cnt16[7:0], mode);
        send_byte(cnt16[15:8], mode);
        if (count <= DEPTH) begin
            for (int i = 0; i < count; i++) begin
                w = img_q[i];
                for (int k = 0; k < 4; k++) begin
                    send_byte(w[8*k +: 8], mode);
                    csum = csum ^ w[8*k +: 8];
                end
            end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            send_byte(csum ^ {7'd0, corrupt}, mode);
`endif
        end
        wait_outcome(ok);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset            = 1'b0;
        start            = 1'b0;
        bus.Byte_i       = 8'h00;
        bus.Byte_Valid_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_core_reset", {31'd0, core_reset}, 32'd0);
        check("rst_ready", {31'd0, bus.Byte_Ready_o}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_error", {31'd0, error}, 32'd0);
        check("rst_mem_write", {31'd0, bus.Mem_Write_o}, 32'd0);
        check("rst_addr", bus.Mem_Address_o, BASE);
        check("rst_data", bus.Mem_Data_o, 32'd0);

        // Two-word image at full valid, then with valid toggling
        img_q = '{32'h00A0_0513, 32'h00B0_0593};
        run_image(2, 0, 1'b0);
        pulse_start();
        run_image(2, 1, 1'b0);
        pulse_start();

        // Length overflow: error flagged right after the second header byte
        run_image(65, 0, 1'b0);
        check("overflow_latency", 32'(last_wait), 32'd0);
        pulse_start();
        run_image(256, 2, 1'b0);
        pulse_start();

        // Empty image
        img_q.delete();
        run_image(0, 0, 1'b0);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
        check("empty_done_latency", 32'(last_wait), 32'd1);
`endif
        pulse_start();

        // Async reset after three data bytes
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        send_byte(8'h13, 0);
        send_byte(8'h05, 0);
        send_byte(8'hA0, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus.Byte_Ready_o}, 32'd1);
        check("mid_rst_mem_write", {31'd0, bus.Mem_Write_o}, 32'd0);
        check("mid_rst_addr", bus.Mem_Address_o, BASE);
        check("mid_rst_data", bus.Mem_Data_o, 32'd0);
        check("mid_rst_core_reset", {31'd0, core_reset}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Randomized images, including the full-depth boundary
        for (int r = 0; r < 6; r++) begin
            n = (r == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            img_q.delete();
            for (int i = 0; i < n; i++) img_q.push_back($urandom);
            run_image(n, r % 3, 1'b0);
            pulse_start();
        end

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        img_q = '{32'h00A0_0513, 32'h00B0_0593};
        run_image(2, 0, 1'b1);
        pulse_start();
        img_q.delete();
        for (int i = 0; i < 5; i++) img_q.push_back($urandom);
        run_image(5, 2, 1'b1);
        pulse_start();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
